// File: rtl/ghash_pkg.sv
// ghash_pkg: shared definitions for the GHASH engine.
//   GF128_W       - field / block width (128)
//   GF128_R       - right-shift reduction constant for x^128 + x^7 + x^2 + x + 1
//   ghash_state_e - control FSM states
package ghash_pkg;

   localparam int unsigned GF128_W = 128;

   // Bit 127 is the x^0 coefficient, so the low-order terms 1 + x + x^2 + x^7
   // land in the top byte as 8'b1110_0001.
   localparam logic [GF128_W-1:0] GF128_R = {8'hE1, 120'd0};

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_BLK = 2'd1,
      MUL      = 2'd2,
      TAG      = 2'd3
   } ghash_state_e;

endpackage

// File: rtl/gf128_mul_serial.sv
// gf128_mul_serial: digit-serial GF(2^128) multiplier, Z = X * H.
//   clk, rst   - clock, asynchronous active-low reset
//   load_i     - capture x_i / h_i and start a new product
//   x_i, h_i   - operands (bit 127 = x^0 coefficient)
//   done_o     - high in the cycle whose clock edge consumes the final digit
//   z_o        - next accumulator value; the finished product while done_o is high
// Consumes DIGIT_W bits of X per cycle, MSB first, so a product takes
// GF128_W/DIGIT_W cycles after the load edge.
module gf128_mul_serial
   import ghash_pkg::*;
#(
   parameter int unsigned DIGIT_W = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               load_i,
   input  logic [GF128_W-1:0] x_i,
   input  logic [GF128_W-1:0] h_i,
   output logic               done_o,
   output logic [GF128_W-1:0] z_o
);

   localparam int unsigned NUM_DIGITS = GF128_W / DIGIT_W;
   localparam int unsigned CNT_W      = $clog2(NUM_DIGITS + 1);

   logic [GF128_W-1:0] r_x;
   logic [GF128_W-1:0] r_v;
   logic [GF128_W-1:0] r_z;
   logic [CNT_W-1:0]   r_cnt;   // digits still to consume; 0 when idle

   logic [GF128_W-1:0] w_z_nxt;
   logic [GF128_W-1:0] w_v_nxt;

   // One digit: for each bit, conditionally accumulate V, then V *= x.
   always_comb begin
      w_z_nxt = r_z;
      w_v_nxt = r_v;
      for (int j = 0; j < DIGIT_W; j++) begin
         if (r_x[GF128_W-1-j]) begin
            w_z_nxt = w_z_nxt ^ w_v_nxt;
         end
         w_v_nxt = {1'b0, w_v_nxt[GF128_W-1:1]} ^ (w_v_nxt[0] ? GF128_R : '0);
      end
   end

   assign done_o = (r_cnt == CNT_W'(1));
   assign z_o    = w_z_nxt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_x   <= '0;
         r_v   <= '0;
         r_z   <= '0;
         r_cnt <= '0;
      end else if (load_i) begin
         r_x   <= x_i;
         r_v   <= h_i;
         r_z   <= '0;
         r_cnt <= CNT_W'(NUM_DIGITS);
      end else if (r_cnt != '0) begin
         r_x   <= r_x << DIGIT_W;
         r_v   <= w_v_nxt;
         r_z   <= w_z_nxt;
         r_cnt <= r_cnt - CNT_W'(1);
      end
   end

endmodule

// File: rtl/ghash_engine.sv
// ghash_engine: GHASH accumulator Y = (Y ^ block) * H over a message of blocks.
//   clk, rst          - clock, asynchronous active-low reset
//   h_i, start_i      - hash subkey, latched with start_i in IDLE (clears Y)
//   blk_valid_i/blk_ready_o, blk_data_i, blk_last_i - block stream
//   tag_valid_o/tag_ready_i, tag_o                   - final GHASH result
//   busy_o            - high whenever the engine is not IDLE
// Timing: a block accepted on edge E0 is multiplied on edges E1..E(128/DIGIT_W);
// the next block can be accepted on the following edge, and a tag appears
// one edge after the last product completes.
module ghash_engine
   import ghash_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = GF128_W,
   parameter int unsigned DIGIT_W    = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] h_i,
   input  logic                  start_i,
   input  logic                  blk_valid_i,
   output logic                  blk_ready_o,
   input  logic [DATA_WIDTH-1:0] blk_data_i,
   input  logic                  blk_last_i,
   output logic                  tag_valid_o,
   input  logic                  tag_ready_i,
   output logic [DATA_WIDTH-1:0] tag_o,
   output logic                  busy_o
);

   ghash_state_e          r_state;
   logic [DATA_WIDTH-1:0] r_h;
   logic [DATA_WIDTH-1:0] r_y;
   logic [DATA_WIDTH-1:0] r_tag;
   logic                  r_last;
   logic                  r_blk_ready;
   logic                  r_tag_valid;
   logic                  r_busy;

   logic                  w_accept;
   logic                  w_mul_done;
   logic [DATA_WIDTH-1:0] w_mul_x;
   logic [DATA_WIDTH-1:0] w_mul_z;

   // r_blk_ready is only ever set while in WAIT_BLK.
   assign w_accept = r_blk_ready & blk_valid_i;
   assign w_mul_x  = r_y ^ blk_data_i;

   gf128_mul_serial #(
      .DIGIT_W (DIGIT_W)
   ) u_mul (
      .clk    (clk),
      .rst    (rst),
      .load_i (w_accept),
      .x_i    (w_mul_x),
      .h_i    (r_h),
      .done_o (w_mul_done),
      .z_o    (w_mul_z)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= IDLE;
         r_h         <= '0;
         r_y         <= '0;
         r_tag       <= '0;
         r_last      <= 1'b0;
         r_blk_ready <= 1'b0;
         r_tag_valid <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         unique case (r_state)
            IDLE: begin
               if (start_i) begin
                  r_h         <= h_i;
                  r_y         <= '0;
                  r_last      <= 1'b0;
                  r_blk_ready <= 1'b1;
                  r_busy      <= 1'b1;
                  r_state     <= WAIT_BLK;
               end
            end
            WAIT_BLK: begin
               if (w_accept) begin
                  r_last      <= blk_last_i;
                  r_blk_ready <= 1'b0;
                  r_state     <= MUL;
               end
            end
            MUL: begin
               if (w_mul_done) begin
                  r_y <= w_mul_z;
                  if (r_last) begin
                     r_tag   <= w_mul_z;
                     r_state <= TAG;
                  end else begin
                     r_blk_ready <= 1'b1;
                     r_state     <= WAIT_BLK;
                  end
               end
            end
            TAG: begin
               // First TAG cycle only raises tag_valid_o, so a tag_ready_i
               // held high early cannot complete a handshake on an unseen tag.
               if (!r_tag_valid) begin
                  r_tag_valid <= 1'b1;
               end else if (tag_ready_i) begin
                  r_tag_valid <= 1'b0;
                  r_busy      <= 1'b0;
                  r_state     <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign blk_ready_o = r_blk_ready;
   assign tag_valid_o = r_tag_valid;
   assign tag_o       = r_tag;
   assign busy_o      = r_busy;

endmodule

// File: tb/tb_ghash_engine.sv
module tb_ghash_engine;

   typedef logic [127:0] blk_t;

   typedef struct {
      blk_t h;
      blk_t d;
      blk_t exp;
   } vec_t;

   localparam blk_t ONE  = 128'h80000000000000000000000000000000;
   localparam blk_t XP1  = 128'h40000000000000000000000000000000;
   localparam blk_t XP2  = 128'h20000000000000000000000000000000;
   localparam blk_t X64  = 128'h00000000000000008000000000000000;
   localparam blk_t X127 = 128'h00000000000000000000000000000001;
   localparam blk_t RED  = 128'hE1000000000000000000000000000000;
   localparam blk_t PAT  = 128'h1234567890ABCDEF1234567890ABCDEF;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks     = 0;
   int failures   = 0;
   int lanes_done = 0;

   // Reference: carry-less polynomial product of the bit-reversed operands,
   // then reduction of every term x^i (i >= 128) using x^128 = x^7+x^2+x+1.
   function automatic blk_t gf_mul_ref(blk_t a, blk_t b);
      logic [254:0] p;
      logic [254:0] bb;
      logic [127:0] ar;
      logic [127:0] br;
      blk_t         r;
      for (int i = 0; i < 128; i++) begin
         ar[i] = a[127-i];
         br[i] = b[127-i];
      end
      p  = '0;
      bb = {127'd0, br};
      for (int i = 0; i < 128; i++) begin
         if (ar[i]) p = p ^ (bb << i);
      end
      for (int i = 254; i >= 128; i--) begin
         if (p[i]) begin
            p[i]     = 1'b0;
            p[i-128] = ~p[i-128];
            p[i-127] = ~p[i-127];
            p[i-126] = ~p[i-126];
            p[i-121] = ~p[i-121];
         end
      end
      for (int i = 0; i < 128; i++) r[127-i] = p[i];
      return r;
   endfunction

   function automatic blk_t rand_blk();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic chk(input string name, input blk_t act, input blk_t exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk_i(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // ---------------- directed DUT (DIGIT_W = 8) ----------------
   logic rst, start_i, bv, bl, tr, br, tv, busy;
   blk_t h_i, bd, tag;

   ghash_engine #(
      .DATA_WIDTH (128),
      .DIGIT_W    (8)
   ) u_dut (
      .clk         (clk),
      .rst         (rst),
      .h_i         (h_i),
      .start_i     (start_i),
      .blk_valid_i (bv),
      .blk_ready_o (br),
      .blk_data_i  (bd),
      .blk_last_i  (bl),
      .tag_valid_o (tv),
      .tag_ready_i (tr),
      .tag_o       (tag),
      .busy_o      (busy)
   );

   // All directed tasks start and end just after a rising edge.
   task automatic do_start(input blk_t h);
      start_i = 1'b1;
      h_i     = h;
      @(posedge clk); #1;
      start_i = 1'b0;
      h_i     = rand_blk();
   endtask

   task automatic send_blk(input blk_t d, input logic last);
      int ok;
      ok = 0;
      bv = 1'b1;
      bd = d;
      bl = last;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (br) begin ok = 1; break; end
      end
      @(posedge clk); #1;
      bv = 1'b0;
      bd = rand_blk();
      if (ok == 0) chk_i("blk accept timeout", ok, 1);
   endtask

   // Counts rising edges after the accepting edge until tag_valid_o is seen.
   task automatic wait_tag(output int edges);
      int ok;
      ok    = 0;
      edges = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (tv) begin ok = 1; break; end
         edges++;
      end
      if (ok == 0) chk_i("tag_valid timeout", ok, 1);
   endtask

   task automatic take_tag();
      tr = 1'b1;
      @(posedge clk); #1;
      tr = 1'b0;
   endtask

   vec_t tbl [6];

   initial begin
      int   lat;
      int   rdy_cnt;
      int   ok;
      int   stable;
      blk_t h;
      blk_t d;
      blk_t e;

      rst = 1'b0; start_i = 1'b0; h_i = '0; bv = 1'b0; bd = '0; bl = 1'b0; tr = 1'b0;

      tbl[0] = '{h: ONE,  d: PAT, exp: PAT};
      tbl[1] = '{h: 128'hDEADBEEF0123456789ABCDEFCAFEF00D, d: '0, exp: '0};
      tbl[2] = '{h: X127, d: XP1, exp: RED};
      tbl[3] = '{h: X64,  d: X64, exp: RED};
      tbl[4] = '{h: XP1,  d: XP1, exp: XP2};
      tbl[5] = '{h: PAT,  d: ONE, exp: PAT};

      @(negedge clk);
      chk("reset tag_o", tag, '0);
      chk_i("reset tv/br/busy", int'({tv, br, busy}), 0);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;

      // Single last-block messages with fixed expected tags and latency.
      for (int k = 0; k < 6; k++) begin
         do_start(tbl[k].h);
         send_blk(tbl[k].d, 1'b1);
         wait_tag(lat);
         chk($sformatf("vec%0d tag", k), tag, tbl[k].exp);
         chk_i($sformatf("vec%0d latency", k), lat, 17);
         take_tag();
         @(negedge clk);
         chk_i($sformatf("vec%0d idle after tag", k), int'({tv, busy}), 0);
         @(posedge clk); #1;
      end

      // Chaining, back-to-back acceptance, start_i/H ignored mid-message,
      // tag_ready_i held high before TAG.
      do_start(XP1);
      send_blk(ONE, 1'b0);
      start_i = 1'b1; h_i = '1; tr = 1'b1;
      bv = 1'b1; bd = '0; bl = 1'b1;
      lat = 0; rdy_cnt = 0; ok = 0;
      for (int i = 0; i < 80; i++) begin
         @(negedge clk);
         if (br) rdy_cnt++;
         if (tv) begin ok = 1; break; end
         lat++;
      end
      start_i = 1'b0; bv = 1'b0;
      chk_i("chain tag seen", ok, 1);
      chk("chain tag", tag, XP2);
      chk_i("chain total cycles", lat, 34);
      chk_i("chain ready cycles", rdy_cnt, 1);
      @(posedge clk); #1;
      tr = 1'b0;
      stable = 1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (tv || busy) stable = 0;
      end
      chk_i("chain single tag", stable, 1);

      // IDLE ignores blk_valid_i.
      bv = 1'b1; bd = rand_blk(); bl = 1'b1;
      stable = 1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (br || busy) stable = 0;
      end
      chk_i("idle ignores blk_valid", stable, 1);
      bv = 1'b0;
      @(posedge clk); #1;

      // Backpressure: tag held stable for 10 cycles.
      h = rand_blk(); d = rand_blk(); e = gf_mul_ref(d, h);
      do_start(h);
      send_blk(d, 1'b1);
      wait_tag(lat);
      stable = 1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (!(tv && tag === e)) stable = 0;
      end
      chk_i("backpressure stable", stable, 1);
      chk("backpressure tag", tag, e);
      take_tag();

      // Reset mid-MUL discards the product.
      do_start(rand_blk());
      send_blk(rand_blk(), 1'b1);
      repeat (5) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("mid-mul reset tag_o", tag, '0);
      chk_i("mid-mul reset tv/br/busy", int'({tv, br, busy}), 0);
      @(posedge clk); #1;
      rst = 1'b1;
      stable = 1;
      for (int i = 0; i < 25; i++) begin
         @(negedge clk);
         if (tv || busy) stable = 0;
      end
      chk_i("no tag after reset", stable, 1);
      @(posedge clk); #1;
      h = rand_blk(); d = rand_blk();
      do_start(h);
      send_blk(d, 1'b0);
      send_blk(ONE, 1'b1);
      wait_tag(lat);
      chk("post-reset tag", tag, gf_mul_ref(gf_mul_ref(d, h) ^ ONE, h));
      take_tag();

      ok = 0;
      for (int i = 0; i < 90000; i++) begin
         @(posedge clk);
         if (lanes_done == 5) begin ok = 1; break; end
      end
      chk_i("random lanes finished", ok, 1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // ---------------- randomized lanes, one per DIGIT_W ----------------
   for (genvar g = 0; g < 5; g++) begin : g_lane
      localparam int unsigned DW   = 1 << g;
      localparam int          NMSG = 40000 / ((128 / DW + 4) * 5);

      logic l_rst, l_start, l_bv, l_bl, l_tr, l_br, l_tv, l_busy;
      blk_t l_h, l_bd, l_tag;

      ghash_engine #(
         .DATA_WIDTH (128),
         .DIGIT_W    (DW)
      ) u_lane (
         .clk         (clk),
         .rst         (l_rst),
         .h_i         (l_h),
         .start_i     (l_start),
         .blk_valid_i (l_bv),
         .blk_ready_o (l_br),
         .blk_data_i  (l_bd),
         .blk_last_i  (l_bl),
         .tag_valid_o (l_tv),
         .tag_ready_i (l_tr),
         .tag_o       (l_tag),
         .busy_o      (l_busy)
      );

      initial begin
         blk_t y;
         blk_t h;
         blk_t d;
         int   nb;
         int   ok;
         int   stable;
         l_rst = 1'b0; l_start = 1'b0; l_bv = 1'b0; l_bl = 1'b0; l_tr = 1'b0;
         l_h = '0; l_bd = '0;
         repeat (3) @(posedge clk);
         #1 l_rst = 1'b1;
         @(posedge clk); #1;
         for (int m = 0; m < NMSG; m++) begin
            h  = rand_blk();
            nb = $urandom_range(1, 8);
            y  = '0;
            l_start = 1'b1; l_h = h;
            @(posedge clk); #1;
            l_start = 1'b0;
            for (int b = 0; b < nb; b++) begin
               d = rand_blk();
               // Gaps carry stray start_i pulses and a changing h_i.
               repeat ($urandom_range(0, 3)) begin
                  l_start = 1'($urandom_range(0, 1));
                  l_h     = rand_blk();
                  @(posedge clk); #1;
               end
               l_start = 1'b0;
               l_bv = 1'b1; l_bd = d; l_bl = (b == nb - 1);
               ok = 0;
               for (int i = 0; i < 400; i++) begin
                  @(negedge clk);
                  if (l_br) begin ok = 1; break; end
               end
               @(posedge clk); #1;
               l_bv = 1'b0; l_bd = rand_blk(); l_bl = 1'($urandom_range(0, 1));
               if (ok == 0) chk_i($sformatf("lane%0d accept timeout", DW), ok, 1);
               y = gf_mul_ref(y ^ d, h);
            end
            l_tr = 1'($urandom_range(0, 1));
            ok = 0;
            for (int i = 0; i < 400; i++) begin
               @(negedge clk);
               if (l_tv) begin ok = 1; break; end
            end
            chk_i($sformatf("lane%0d tag_valid", DW), ok, 1);
            chk($sformatf("lane%0d msg%0d tag", DW, m), l_tag, y);
            if (!l_tr) begin
               stable = 1;
               repeat ($urandom_range(0, 3)) begin
                  @(negedge clk);
                  if (!(l_tv && l_tag === y)) stable = 0;
               end
               if (stable == 0) chk_i($sformatf("lane%0d tag hold", DW), stable, 1);
               l_tr = 1'b1;
            end
            @(posedge clk); #1;
            l_tr = 1'b0;
            @(negedge clk);
            chk_i($sformatf("lane%0d single tag", DW), int'({l_tv, l_busy}), 0);
            @(posedge clk); #1;
         end
         lanes_done++;
      end
   end

endmodule
